// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder byte-stream feeder.
package aq_djpeg_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_DRAIN  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/aq_djpeg_feeder_fifo.sv
// First-word-fall-through word FIFO; head word is read combinationally.
module aq_djpeg_feeder_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [31:0]   wdata,
  input  logic          rd,
  output logic [31:0]   rdata,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count_reg == '0);
  assign level = count_reg;
  assign rdata = mem[rd_ptr_reg];
  // A pop on an empty FIFO is dropped so the pointers never run past the data.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (count_reg != FULL_LEVEL);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/aq_djpeg_feeder.sv
// Packs an 8-bit JPEG byte stream big-endian into 32-bit words for the decoder,
// sequences one image at a time and keeps per-image byte/stall statistics.
module aq_djpeg_feeder
  import aq_djpeg_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  output logic [31:0]        DataIn,
  output logic               DataInEnable,
  input  logic               DataInRead,
  input  logic               DataInReq,
  input  logic               JpegDecodeIdle,
  output logic [FIFO_AW:0]   FifoLevel,
  output logic [31:0]        ByteCount,
  output logic [31:0]        StallCycles,
  output logic               FrameDone
);

  localparam logic [FIFO_AW:0] DEPTH_LEVEL = (FIFO_AW + 1)'(FIFO_DEPTH);

  feed_state_t st_reg;
  feed_state_t st_next;
  logic [1:0]  bcnt_reg;
  logic [23:0] hold_reg;
  logic [31:0] word;
  logic [31:0] byte_count_reg;
  logic [31:0] stall_reg;
  logic        accept;
  logic        push;
  logic        fifo_empty;

  assign s_tready     = (st_reg == FEED_STREAM) && (FifoLevel < DEPTH_LEVEL);
  assign accept       = s_tvalid && s_tready;
  assign push         = accept && ((bcnt_reg == 2'd3) || s_tlast);
  assign DataInEnable = !fifo_empty;
  assign ByteCount    = byte_count_reg;
  assign StallCycles  = stall_reg;

  // Lanes below the incoming byte are forced to zero so a short tail word is clean.
  always_comb begin
    word = {hold_reg, s_tdata};
    case (bcnt_reg)
      2'd0:    word = {s_tdata, 24'h000000};
      2'd1:    word = {hold_reg[23:16], s_tdata, 16'h0000};
      2'd2:    word = {hold_reg[23:8], s_tdata, 8'h00};
      default: word = {hold_reg, s_tdata};
    endcase
  end

  always_comb begin
    st_next   = st_reg;
    FrameDone = 1'b0;
    case (st_reg)
      FEED_IDLE: begin
        if (s_tvalid) st_next = FEED_STREAM;
      end
      FEED_STREAM: begin
        if (accept && s_tlast) st_next = FEED_DRAIN;
      end
      FEED_DRAIN: begin
        if (fifo_empty && JpegDecodeIdle) begin
          st_next   = FEED_IDLE;
          FrameDone = 1'b1;
        end
      end
      default: st_next = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg   <= FEED_IDLE;
      bcnt_reg <= 2'd0;
      hold_reg <= 24'h000000;
    end else begin
      st_reg <= st_next;
      if (accept) begin
        hold_reg <= word[31:8];
        bcnt_reg <= push ? 2'd0 : bcnt_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count_reg <= 32'd0;
      stall_reg      <= 32'd0;
    end else if ((st_reg == FEED_IDLE) && (st_next == FEED_STREAM)) begin
      byte_count_reg <= 32'd0;
      stall_reg      <= 32'd0;
    end else begin
      if (accept) begin
        byte_count_reg <= byte_count_reg + 32'd1;
      end
      if ((st_reg != FEED_IDLE) && DataInReq && fifo_empty && (stall_reg != '1)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end
  end

  aq_djpeg_feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .wdata (word),
    .rd    (DataInRead),
    .rdata (DataIn),
    .empty (fifo_empty),
    .level (FifoLevel)
  );

endmodule

// File: tb/tb_aq_djpeg_feeder.sv
// Self-checking bench for aq_djpeg_feeder: byte table plus word scoreboard.
module tb_aq_djpeg_feeder;

  logic        clk;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] DataIn;
  logic        DataInEnable;
  logic        DataInRead;
  logic        DataInReq;
  logic        JpegDecodeIdle;
  logic [4:0]  FifoLevel;
  logic [31:0] ByteCount;
  logic [31:0] StallCycles;
  logic        FrameDone;

  aq_djpeg_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tlast        (s_tlast),
    .DataIn         (DataIn),
    .DataInEnable   (DataInEnable),
    .DataInRead     (DataInRead),
    .DataInReq      (DataInReq),
    .JpegDecodeIdle (JpegDecodeIdle),
    .FifoLevel      (FifoLevel),
    .ByteCount      (ByteCount),
    .StallCycles    (StallCycles),
    .FrameDone      (FrameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [31:0] exp_bc;
    logic        push;
    logic [31:0] word;
  } vec_t;

  vec_t        vec [13];
  logic [31:0] exp_q [$];
  int          vectors;
  int          miscompares;
  int          fd_cnt;
  bit          auto_pop;
  bit          man_read;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%08h want=%08h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    DataInRead = auto_pop ? 1'($urandom_range(0, 1)) : man_read;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc;
    int n;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 64) begin
      acc = s_tready;
      tick();
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout got=no_accept want=accept byte=%02h", d);
    end
  endtask

  task automatic wait_frame(input string nm);
    int fd0;
    int n;
    fd0 = fd_cnt;
    n = 0;
    while (fd_cnt == fd0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({nm, "_pulses"}, 32'(fd_cnt - fd0), 32'd1);
    check({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_tready"}, 32'(s_tready), 32'd0);
    check({nm, "_enable"}, 32'(DataInEnable), 32'd0);
    check({nm, "_level"}, 32'(FifoLevel), 32'd0);
    check({nm, "_bytecount"}, ByteCount, 32'd0);
    check({nm, "_stall"}, StallCycles, 32'd0);
    check({nm, "_framedone"}, 32'(FrameDone), 32'd0);
  endtask

  // Decoder-side monitor: every pop is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [31:0] w;
    if (!rst) begin
      if (FrameDone) fd_cnt++;
      if (DataInEnable && DataInRead) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected got=%08h want=none", DataIn);
        end else begin
          w = exp_q.pop_front();
          if (DataIn !== w) begin
            miscompares++;
            $display("FAIL pop_word got=%08h want=%08h", DataIn, w);
          end else begin
            $display("pop word %08h", DataIn);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int acc_cnt;
    bit acc;

    vec[0]  = '{8'hFF, 1'b0, 32'd1, 1'b0, 32'h0};
    vec[1]  = '{8'hD8, 1'b0, 32'd2, 1'b0, 32'h0};
    vec[2]  = '{8'hFF, 1'b0, 32'd3, 1'b0, 32'h0};
    vec[3]  = '{8'hE0, 1'b0, 32'd4, 1'b1, 32'hFFD8FFE0};
    vec[4]  = '{8'h12, 1'b0, 32'd5, 1'b0, 32'h0};
    vec[5]  = '{8'h34, 1'b0, 32'd6, 1'b0, 32'h0};
    vec[6]  = '{8'h56, 1'b0, 32'd7, 1'b0, 32'h0};
    vec[7]  = '{8'h78, 1'b1, 32'd8, 1'b1, 32'h12345678};
    vec[8]  = '{8'hAA, 1'b0, 32'd1, 1'b0, 32'h0};
    vec[9]  = '{8'hBB, 1'b0, 32'd2, 1'b0, 32'h0};
    vec[10] = '{8'hCC, 1'b0, 32'd3, 1'b0, 32'h0};
    vec[11] = '{8'hDD, 1'b0, 32'd4, 1'b1, 32'hAABBCCDD};
    vec[12] = '{8'hEE, 1'b1, 32'd5, 1'b1, 32'hEE000000};

    vectors = 0;
    miscompares = 0;
    fd_cnt = 0;
    rst = 1'b1;
    s_tdata = 8'h00;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    DataInRead = 1'b0;
    DataInReq = 1'b0;
    JpegDecodeIdle = 1'b1;
    auto_pop = 1'b0;
    man_read = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset("reset");

    // Basic packing and partial tail, random decoder pops
    auto_pop = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send_byte(vec[i].data, vec[i].last);
      if (vec[i].push) exp_q.push_back(vec[i].word);
      check($sformatf("bytecount_%0d", i), ByteCount, vec[i].exp_bc);
      if (vec[i].last) wait_frame($sformatf("frame_%0d", i));
    end

    // Stall counting and reads on an empty FIFO
    auto_pop = 1'b0;
    man_read = 1'b0;
    s_tdata = 8'h11;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    check("stall_entry_bytecount", ByteCount, 32'd0);
    DataInReq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      man_read = k[0];
      tick();
    end
    DataInReq = 1'b0;
    man_read = 1'b0;
    check("stall_cycles", StallCycles, 32'd10);
    check("stall_level", 32'(FifoLevel), 32'd0);
    check("stall_enable", 32'(DataInEnable), 32'd0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
    exp_q.push_back(32'h12345678);
    check("after_empty_read_level", 32'(FifoLevel), 32'd1);
    check("after_empty_read_head", DataIn, 32'h12345678);
    auto_pop = 1'b1;
    wait_frame("frame_stall");

    // Drain gated by a busy decoder
    JpegDecodeIdle = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    exp_q.push_back(32'h01020300);
    b = fd_cnt;
    repeat (30) tick();
    check("gate_drained", 32'(exp_q.size()), 32'd0);
    check("gate_no_framedone", 32'(fd_cnt - b), 32'd0);
    check("gate_tready", 32'(s_tready), 32'd0);
    DataInReq = 1'b1;
    repeat (5) tick();
    DataInReq = 1'b0;
    check("gate_stall", StallCycles, 32'd5);
    JpegDecodeIdle = 1'b1;
    tick();
    tick();
    check("gate_framedone", 32'(fd_cnt - b), 32'd1);
    send_byte(8'hC0, 1'b0);
    check("next_image_bytecount", ByteCount, 32'd1);
    check("next_image_stall", StallCycles, 32'd0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b1);
    exp_q.push_back(32'hC0C1C2C3);
    wait_frame("frame_next");

    // Fill the FIFO with no decoder pops
    auto_pop = 1'b0;
    man_read = 1'b0;
    b = 0;
    acc_cnt = 0;
    s_tdata = 8'h00;
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      acc = s_tready;
      tick();
      if (acc) begin
        b++;
        s_tdata = 8'(b);
      end
    end
    s_tvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)});
    end
    check("full_bytes_accepted", 32'(b), 32'd64);
    check("full_level", 32'(FifoLevel), 32'd16);
    check("full_tready", 32'(s_tready), 32'd0);
    man_read = 1'b1;
    tick();
    man_read = 1'b0;
    tick();
    check("full_level_after_pop", 32'(FifoLevel), 32'd15);
    acc_cnt = b;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = s_tready;
      tick();
      if (acc) begin
        b++;
        s_tdata = 8'(b);
      end
    end
    s_tvalid = 1'b0;
    exp_q.push_back(32'h40414243);
    check("reopen_bytes_accepted", 32'(b - acc_cnt), 32'd4);
    check("reopen_level", 32'(FifoLevel), 32'd16);
    check("reopen_bytecount", ByteCount, 32'd68);
    do_reset();
    check_reset("reset_after_full");

    // Reset in the middle of an image
    for (int k = 0; k < 6; k++) send_byte(8'(8'h21 + k), 1'b0);
    check("mid_level", 32'(FifoLevel), 32'd1);
    check("mid_bytecount", ByteCount, 32'd6);
    do_reset();
    check_reset("reset_mid");
    auto_pop = 1'b1;
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h34, 1'b1);
    exp_q.push_back(32'h31323334);
    check("post_reset_bytecount", ByteCount, 32'd4);
    wait_frame("frame_post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_feeder.md
# aq_djpeg_feeder

Byte-stream front end for the JPEG decoder input port. Accepts a JPEG file as an 8-bit AXI4-Stream, packs the bytes big-endian into 32-bit words, buffers them in a first-word-fall-through (FWFT) FIFO, and presents them on the decoder's `DataIn`/`DataInEnable`/`DataInRead`/`DataInReq` port. It also sequences one image at a time and reports per-image byte and stall statistics.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: word FIFO depth. Must be a power of two, ≥ 4.
- `FIFO_AW`, default 4: log2(`FIFO_DEPTH`).

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `s_tdata` input 8: JPEG byte, in file order.
- `s_tvalid` input 1: byte valid.
- `s_tready` output 1: byte accepted when `s_tvalid && s_tready`.
- `s_tlast` input 1: last byte of the image.
- `DataIn` output 32: FIFO head word. The first file byte is in [31:24].
- `DataInEnable` output 1: FIFO not empty; `DataIn` is valid.
- `DataInRead` input 1: pop strobe from the decoder.
- `DataInReq` input 1: decoder data-request level.
- `JpegDecodeIdle` input 1: decoder idle (1 = idle).
- `FifoLevel` output `FIFO_AW`+1: number of words held.
- `ByteCount` output 32: bytes accepted in the current image.
- `StallCycles` output 32: cycles in which `DataInReq` was high and `DataInEnable` was low, counted in the current image.
- `FrameDone` output 1: one-cycle pulse when the image has fully drained.

## Operation
- **State machine `st`**: IDLE, STREAM, DRAIN.
  - IDLE to STREAM: when `s_tvalid` is high. On entry, `ByteCount` and `StallCycles` clear to 0.
  - STREAM to DRAIN: when a byte is accepted with `s_tlast` = 1.
  - DRAIN to IDLE: when the FIFO is empty and `JpegDecodeIdle` = 1. Assert `FrameDone` for that cycle.
- **`s_tready`**: equals (`st` == STREAM) && (`FifoLevel` < `FIFO_DEPTH`). It is low in IDLE, low in DRAIN, and low when the FIFO is full.
- **Packer**:
  - A 2-bit byte counter `bcnt` and a 24-bit holding register.
  - An accepted byte is placed at lane 3-`bcnt`.
  - When `bcnt` == 3 or `s_tlast` = 1, the assembled word is written to the FIFO in the same cycle and `bcnt` returns to 0.
  - On a partial word at `s_tlast`, the unfilled lower lanes are 0x00.
- **FIFO**:
  - Write pointer, read pointer, and a count of width `FIFO_AW`+1.
  - `DataIn` = `mem[rd_ptr]`, read combinationally (FWFT).
  - A pop occurs when `DataInRead && DataInEnable`. `DataInRead` while the FIFO is empty is ignored, and the pointers do not move.
  - A simultaneous push and pop leaves the count unchanged.
- **`ByteCount`**: +1 per accepted byte. Wraps modulo 2^32.
- **`StallCycles`**: +1 in each cycle with `st` != IDLE && `DataInReq` && !`DataInEnable`. Saturates at 0xFFFF_FFFF.
- **Reset** (valid at any time, including mid-image):
  - `st` = IDLE, FIFO empty, `bcnt` = 0.
  - `s_tready` = 0, `DataInEnable` = 0, `FifoLevel` = 0, `ByteCount` = 0, `StallCycles` = 0, `FrameDone` = 0.
  - `DataIn` is don't-care while `DataInEnable` = 0.
  - Partial words are discarded.

## Timing
- A word completed in cycle N is visible with `DataInEnable` = 1 in cycle N+1.
- A pop in cycle N presents the next word (or `DataInEnable` = 0) in cycle N+1.
- `s_tready` is registered-state based and falls in the cycle after the FIFO reaches `FIFO_DEPTH`.
  - While `FifoLevel` = `FIFO_DEPTH`-1, accepting the byte that completes a word is legal, with or without a same-cycle pop.
- Throughput: 1 byte/cycle in, so at most 1 word every 4 cycles. The decoder can pop 1 word/cycle.
- `FrameDone` is asserted in the cycle that `st` leaves DRAIN. The next image is accepted from the following cycle onward (IDLE to STREAM needs 1 cycle).

## Structure
- Shared package `aq_djpeg_pkg`: holds the state encoding constants `FEED_IDLE`=2'd0, `FEED_STREAM`=2'd1, `FEED_DRAIN`=2'd2.
- One sub-module, `aq_djpeg_feeder_fifo`: a parameterised FWFT word FIFO with ports `wr`, `wdata`, `rd`, `rdata`, `empty`, `level`.
- The packer, FSM and counters live in the top.

## Test plan
- **Basic packing**: reset, then send bytes FF D8 FF E0 12 34 56 78.
  - Two words, FFD8FFE0 then 12345678, in that order.
  - `ByteCount` = 8.
- **Partial tail**: send 5 bytes AA BB CC DD EE with `tlast` on EE.
  - Words AABBCCDD and EE000000.
  - With `JpegDecodeIdle` held at 1 and the FIFO drained, `FrameDone` pulses once.
- **Full FIFO**: `DataInRead` held at 0, stream 80 bytes.
  - `s_tready` falls after exactly 64 bytes; `FifoLevel` = 16.
  - Popping one word reopens `s_tready` for 4 more bytes.
- **Stall and empty read**: `DataInReq` = 1 for 10 cycles with the FIFO empty, plus `DataInRead` pulses.
  - `StallCycles` = 10.
  - Pointers unchanged; `FifoLevel` stays 0.
- **Drain gating**: after `tlast`, hold `JpegDecodeIdle` = 0 with the FIFO empty.
  - No `FrameDone`, and `s_tready` stays 0.
  - Raising `JpegDecodeIdle` gives `FrameDone` 1 cycle later, then a new image is accepted with counters cleared.
- **Reset mid-image**: assert `rst` after 6 bytes.
  - All outputs return to their reset values.
  - The next image's first word is correct, with no stale bytes.
